// File: rtl/multiplier_pkg.sv
// Shared types and sizing for the sequential shift-and-add multiplier.
package multiplier_pkg;
  localparam int MULT_W     = 16;
  localparam int MCAND_W    = 4;
  localparam int PROD_W     = MULT_W + MCAND_W;
  localparam int ITER_CNT_W = 2;
  localparam int ACC_W      = PROD_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/multiplier_datapath.sv
// Accumulator, latched multiplicand-to-add register, 17-bit adder and right shifter.
module multiplier_datapath
  import multiplier_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [MULT_W-1:0]  mult_i,
  input  logic [MCAND_W-1:0] mcand_i,
  output logic [PROD_W-1:0]  prod_o
);
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [MULT_W-1:0] mult_q, mult_d;
  logic [MULT_W:0]   sum;

  always_comb begin
    acc_d  = acc_q;
    mult_d = mult_q;
    // Upper 17 bits keep the carry so the add never loses the MSB before the shift.
    sum    = acc_q[ACC_W-1:MCAND_W] + (acc_q[0] ? {1'b0, mult_q} : {(MULT_W+1){1'b0}});
    if (load_i) begin
      acc_d  = {{(MULT_W+1){1'b0}}, mcand_i};
      mult_d = mult_i;
    end else if (step_i) begin
      acc_d  = {1'b0, sum, acc_q[MCAND_W-1:1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      mult_q <= '0;
    end else begin
      acc_q  <= acc_d;
      mult_q <= mult_d;
    end
  end

  assign prod_o = acc_q[PROD_W-1:0];
endmodule

// File: rtl/multiplier_top.sv
// Control FSM for the 16x4 shift-and-add multiplier with registered product/Done.
module multiplier_top
  import multiplier_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               St,
  input  logic [MULT_W-1:0]  Mult,
  input  logic [MCAND_W-1:0] Mcand,
  output logic [PROD_W-1:0]  product,
  output logic               Done
);
  state_e                state_q;
  logic [ITER_CNT_W-1:0] cnt_q;
  logic [PROD_W-1:0]     product_q;
  logic                  done_q;
  logic                  load, step;
  logic [PROD_W-1:0]     acc_prod;

  // A start is refused while the Done pulse is still high, so it lands on the
  // first edge after Done falls.
  assign load = (state_q == IDLE) && St && !done_q;
  assign step = (state_q == CALC);

  multiplier_datapath u_dp (
    .clk_i   (clock),
    .rst_i   (reset),
    .load_i  (load),
    .step_i  (step),
    .mult_i  (Mult),
    .mcand_i (Mcand),
    .prod_o  (acc_prod)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: if (load) begin
          cnt_q   <= '0;
          state_q <= CALC;
        end
        CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == ITER_CNT_W'(MCAND_W - 1)) state_q <= DONE;
        end
        // Result is latched out on leaving DONE; Done is high the following cycle.
        DONE: begin
          product_q <= acc_prod;
          done_q    <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign product = product_q;
  assign Done    = done_q;
endmodule

// File: tb/tb_multiplier_top.sv
// Randomised and directed bench for multiplier_top against an arithmetic reference.
module tb_multiplier_top;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        St    = 1'b0;
  logic [15:0] Mult  = '0;
  logic [3:0]  Mcand = '0;
  logic [19:0] product;
  logic        Done;

  int          vectors    = 0;
  int          miscompares = 0;
  logic [19:0] exp_prod   = '0;

  multiplier_top dut (
    .clock   (clock),
    .reset   (reset),
    .St      (St),
    .Mult    (Mult),
    .Mcand   (Mcand),
    .product (product),
    .Done    (Done)
  );

  always #5 clock = ~clock;

  // Start an operation and watch 7 cycles; Done must be high only 5 edges after the St edge.
  // Returns at the negedge after Done falls so a chained call starts on the next edge.
  task automatic run_op(input logic [15:0] m, input logic [3:0] c, input int busy_st,
                        input bit chained);
    logic [19:0] exp_new;
    logic [19:0] exp_now;
    exp_new = {4'b0, m} * {16'b0, c};
    if (!chained) @(negedge clock);
    St = 1'b1; Mult = m; Mcand = c;
    @(posedge clock);
    #1;
    St = 1'b0; Mult = 16'($urandom); Mcand = 4'($urandom);
    for (int k = 0; k < 7; k++) begin
      @(negedge clock);
      vectors++;
      if (Done !== (k == 5)) begin
        miscompares++;
        $display("FAIL done_timing op=%0d*%0d cyc=%0d got=%b want=%b", m, c, k, Done, (k == 5));
      end
      exp_now = (k >= 5) ? exp_new : exp_prod;
      vectors++;
      if (product !== exp_now) begin
        miscompares++;
        $display("FAIL product op=%0d*%0d cyc=%0d got=%0d want=%0d", m, c, k, product, exp_now);
      end
      if (k < busy_st) begin
        St = 1'b1; Mult = 16'd7; Mcand = 4'd9;
      end else begin
        St = 1'b0; Mult = 16'($urandom); Mcand = 4'($urandom);
      end
    end
    exp_prod = exp_new;
  endtask

  task automatic test_reset;
    reset = 1'b1; St = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      vectors++;
      if (Done !== 1'b0 || product !== 20'd0) begin
        miscompares++;
        $display("FAIL reset_idle cyc=%0d got done=%b prod=%0d want done=0 prod=0", k, Done, product);
      end
    end
    exp_prod = '0;
  endtask

  task automatic test_directed;
    run_op(16'd18, 4'd5, 0, 1'b0);
    run_op(16'd20, 4'd8, 0, 1'b0);
    run_op(16'd65535, 4'd15, 0, 1'b0);
    run_op(16'd1234, 4'd0, 0, 1'b0);
  endtask

  task automatic test_busy_start;
    run_op(16'd100, 4'd3, 2, 1'b0);
    // The ignored request must not spawn a second operation.
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      vectors++;
      if (Done !== 1'b0 || product !== exp_prod) begin
        miscompares++;
        $display("FAIL busy_ignored cyc=%0d got done=%b prod=%0d want done=0 prod=%0d",
                 k, Done, product, exp_prod);
      end
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clock);
    St = 1'b1; Mult = 16'd500; Mcand = 4'd15;
    @(posedge clock);
    #1 St = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_prod = '0;
    for (int k = 0; k < 10; k++) begin
      vectors++;
      if (Done !== 1'b0 || product !== 20'd0) begin
        miscompares++;
        $display("FAIL reset_abort cyc=%0d got done=%b prod=%0d want done=0 prod=0", k, Done, product);
      end
      @(negedge clock);
    end
    run_op(16'd2, 4'd3, 0, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_op(16'd321, 4'd7, 0, 1'b0);
    run_op(16'd4095, 4'd10, 0, 1'b1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 30; i++)
      run_op(16'($urandom), 4'($urandom), int'($urandom_range(0, 3)), (i > 0) && ($urandom_range(0, 1) == 1));
    run_op(16'($urandom), 4'd15, 0, 1'b0);
    run_op(16'd0, 4'($urandom), 0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
